// File: rtl/mcb_port_emulator_pkg.sv
// Shared definitions for the MCB port emulator: command codes, engine state
// encoding and the packed FIFO entry layouts.
package mcb_port_emulator_pkg;

  localparam logic [2:0] MEM_WRITE    = 3'b000;
  localparam logic [2:0] MEM_READ     = 3'b001;
  localparam logic [2:0] MEM_WRITE_AP = 3'b010;
  localparam logic [2:0] MEM_READ_AP  = 3'b011;
  localparam logic [2:0] MEM_REFRESH  = 3'b100;

  localparam int REFRESH_CYCLES = 4;

  typedef enum logic [1:0] {
    ENG_IDLE    = 2'd0,
    ENG_WRITE   = 2'd1,
    ENG_READ    = 2'd2,
    ENG_REFRESH = 2'd3
  } eng_state_e;

  // 39-bit command FIFO entry: instr + burst length - 1 + byte address
  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_word_t;

endpackage

// File: rtl/mcb_port_emulator_if.sv
// MCB user-port bundle (cmd / wr / rd) between the command block and the emulator.
interface mcb_port_emulator_if;
  // Pushes (cmd_en, wr_en) are taken on a clock edge only when the matching
  // *_full is low, otherwise dropped; rd_data is valid whenever rd_empty is
  // low and rd_en pops it on the edge.
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty;
  logic        cmd_full;

  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        wr_error;

  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  cmd_empty, cmd_full,
    output wr_en, wr_mask, wr_data,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_en,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output cmd_empty, cmd_full,
    input  wr_en, wr_mask, wr_data,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_en,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );
endinterface

// File: rtl/mcb_port_emulator_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Output reads as zero while empty; pushes into a full FIFO are dropped.
module mcb_port_emulator_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_ok ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mcb_port_emulator.sv
// Block-RAM backed MCB user-port responder: queues cmd/wr/rd traffic and
// services it with a single engine FSM on one clock.
module mcb_port_emulator
  import mcb_port_emulator_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  mcb_port_emulator_if.slave   bus,
  output eng_state_e           dbg_state_o
);

  cmd_t       cmd_in, cmd_head;
  wr_word_t   wr_in, wr_head;
  logic       cmd_empty, wr_full, wr_empty, rd_full, rd_empty;
  logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count_unused;

  eng_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [5:0]            remain_q, remain_d;
  logic [1:0]            ref_q, ref_d;
  logic                  cmd_pop, wr_pop, ram_re, underrun, overflow;

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;
  logic        pipe_v_q;
  logic        wr_err_q, rd_err_q;
  logic        unused_addr_bits;

  assign cmd_in = '{instr: bus.cmd_instr, bl: bus.cmd_bl, byte_addr: bus.cmd_byte_addr};
  assign wr_in  = '{mask: bus.wr_mask, data: bus.wr_data};

  mcb_port_emulator_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i(clock), .rst_i(reset),
    .push_i(bus.cmd_en), .din_i(cmd_in),
    .pop_i(cmd_pop), .dout_o(cmd_head),
    .full_o(bus.cmd_full), .empty_o(cmd_empty), .count_o(cmd_count_unused)
  );

  mcb_port_emulator_sync_fifo #(.WIDTH($bits(wr_word_t)), .DEPTH(DATA_DEPTH), .CNT_W(7)) u_wr_fifo (
    .clk_i(clock), .rst_i(reset),
    .push_i(bus.wr_en), .din_i(wr_in),
    .pop_i(wr_pop), .dout_o(wr_head),
    .full_o(wr_full), .empty_o(wr_empty), .count_o(bus.wr_count)
  );

  // The read FIFO is fed straight from the registered RAM output
  mcb_port_emulator_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH), .CNT_W(7)) u_rd_fifo (
    .clk_i(clock), .rst_i(reset),
    .push_i(pipe_v_q), .din_i(rdata_q),
    .pop_i(bus.rd_en), .dout_o(bus.rd_data),
    .full_o(rd_full), .empty_o(rd_empty), .count_o(bus.rd_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ENG_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      ref_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      ref_q    <= ref_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    ref_d    = ref_q;
    unique case (state_q)
      ENG_IDLE: begin
        if (!cmd_empty) begin
          addr_d   = cmd_head.byte_addr[ADDR_WIDTH+1:2];
          remain_d = cmd_head.bl;
          ref_d    = 2'(REFRESH_CYCLES - 1);
          case (cmd_head.instr)
            MEM_WRITE, MEM_WRITE_AP: state_d = ENG_WRITE;
            MEM_READ, MEM_READ_AP:   state_d = ENG_READ;
            MEM_REFRESH:             state_d = ENG_REFRESH;
            default:                 state_d = ENG_IDLE;
          endcase
        end
      end
      ENG_WRITE: begin
        if (!wr_empty) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == '0) state_d = ENG_IDLE;
        end
      end
      ENG_READ: begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == '0) state_d = ENG_IDLE;
      end
      ENG_REFRESH: begin
        ref_d = ref_q - 1'b1;
        if (ref_q == '0) state_d = ENG_IDLE;
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  always_comb begin
    cmd_pop  = (state_q == ENG_IDLE) && !cmd_empty;
    wr_pop   = (state_q == ENG_WRITE) && !wr_empty;
    underrun = (state_q == ENG_WRITE) && wr_empty;
    ram_re   = (state_q == ENG_READ);
    overflow = pipe_v_q && rd_full;
  end

  always_ff @(posedge clock) begin
    if (wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head.mask[b]) mem_q[addr_q][8*b +: 8] <= wr_head.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ram_re) rdata_q <= mem_q[addr_q];
  end

  // The read pipeline never back-pressures the engine: a full FIFO drops the word
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      pipe_v_q <= ram_re;
      wr_err_q <= wr_err_q | (bus.wr_en & wr_full) | underrun;
      rd_err_q <= rd_err_q | (bus.rd_en & rd_empty) | overflow;
    end
  end

  assign bus.cmd_empty   = cmd_empty;
  assign bus.wr_full     = wr_full;
  assign bus.wr_empty    = wr_empty;
  assign bus.wr_underrun = underrun;
  assign bus.wr_error    = wr_err_q;
  assign bus.rd_full     = rd_full;
  assign bus.rd_empty    = rd_empty;
  assign bus.rd_overflow = overflow;
  assign bus.rd_error    = rd_err_q;
  assign dbg_state_o     = state_q;

  assign unused_addr_bits = ^{cmd_head.byte_addr[29:ADDR_WIDTH+2], cmd_head.byte_addr[1:0]};

endmodule

// File: tb/tb_mcb_port_emulator.sv
// Directed bench for mcb_port_emulator: masked-write vector table plus
// hand-written latency, underrun, overflow, FIFO-full, wrap and reset sequences.
module tb_mcb_port_emulator;
  import mcb_port_emulator_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  eng_state_e dbg_state;

  always #5 clock = ~clock;

  mcb_port_emulator_if bus();

  mcb_port_emulator #(.ADDR_WIDTH(10), .CMD_DEPTH(4), .DATA_DEPTH(64)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [29:0] wr_addr;
    logic [29:0] rd_addr;
    logic [31:0] pre;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          uf_cnt = 0;
  int          ov_cnt = 0;
  int          base;

  always @(negedge clock) begin
    if (bus.wr_underrun) uf_cnt++;
    if (bus.rd_overflow) ov_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    bus.cmd_en        = 1'b1;
    bus.cmd_instr     = instr;
    bus.cmd_bl        = bl;
    bus.cmd_byte_addr = addr;
    tick();
    bus.cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] data, input logic [3:0] mask);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    bus.wr_mask = mask;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(dbg_state == ENG_IDLE && bus.cmd_empty) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (!(dbg_state == ENG_IDLE && bus.cmd_empty)) begin
      errors++;
      $display("FAIL %s: engine busy after %0d cycles, expected idle", name, n);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    int n = 0;
    while (bus.rd_empty && n < 50) begin
      tick();
      n++;
    end
    if (bus.rd_empty) begin
      checks++;
      errors++;
      $display("FAIL %s: rd_empty still 1 after %0d cycles, expected word %h", name, n, exp);
    end else begin
      check(name, bus.rd_data, exp);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    logic [31:0] w;
    while (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      pop_check(name, w);
    end
  endtask

  task automatic write_word(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] mask);
    push_wr(data, mask);
    push_cmd(MEM_WRITE, 6'd0, addr);
    wait_idle("write_word");
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_empty"}, bus.cmd_empty, 1);
    check({tag, "_cmd_full"}, bus.cmd_full, 0);
    check({tag, "_wr_empty"}, bus.wr_empty, 1);
    check({tag, "_wr_full"}, bus.wr_full, 0);
    check({tag, "_wr_count"}, bus.wr_count, 0);
    check({tag, "_wr_underrun"}, bus.wr_underrun, 0);
    check({tag, "_wr_error"}, bus.wr_error, 0);
    check({tag, "_rd_empty"}, bus.rd_empty, 1);
    check({tag, "_rd_full"}, bus.rd_full, 0);
    check({tag, "_rd_count"}, bus.rd_count, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
    check({tag, "_rd_overflow"}, bus.rd_overflow, 0);
    check({tag, "_rd_error"}, bus.rd_error, 0);
    check({tag, "_state"}, dbg_state, ENG_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // wr_addr, rd_addr, pre-fill, data, mask (1 = keep), expected readback
    vecs[0] = '{30'h040, 30'h040, 32'h0000_0000, 32'ha5a5_a5a5, 4'b0000, 32'ha5a5_a5a5};
    vecs[1] = '{30'h020, 30'h020, 32'hffff_ffff, 32'h0000_0000, 4'b1010, 32'hff00_ff00};
    vecs[2] = '{30'h3fc, 30'h3fc, 32'h1234_5678, 32'hdead_beef, 4'b0001, 32'hdead_be78};
    vecs[3] = '{30'h1000_0107, 30'h104, 32'h1111_1111, 32'h2222_2222, 4'b1100, 32'h1111_2222};

    bus.cmd_en = 0; bus.cmd_instr = 0; bus.cmd_bl = 0; bus.cmd_byte_addr = 0;
    bus.wr_en = 0; bus.wr_mask = 0; bus.wr_data = 0; bus.rd_en = 0;

    apply_reset();
    check_reset_state("reset");

    // Write two words, read them back and time the first read word
    push_wr(32'hcafe_babe, 4'b0000);
    push_wr(32'h1bad_1dea, 4'b0000);
    push_cmd(MEM_WRITE, 6'd1, 30'h10);
    wait_idle("t1_write");
    push_cmd(MEM_READ, 6'd1, 30'h10);
    check("lat_e0_rd_empty", bus.rd_empty, 1);
    tick();
    check("lat_e1_rd_empty", bus.rd_empty, 1);
    tick();
    check("lat_e2_rd_empty", bus.rd_empty, 1);
    tick();
    check("lat_e3_rd_empty", bus.rd_empty, 0);
    tick();
    check("t1_rd_count", bus.rd_count, 2);
    exp_q.push_back(32'hcafe_babe);
    exp_q.push_back(32'h1bad_1dea);
    drain("t1_data");

    for (int i = 0; i < 4; i++) begin
      write_word(vecs[i].wr_addr, vecs[i].pre, 4'b0000);
      write_word(vecs[i].wr_addr, vecs[i].data, vecs[i].mask);
      push_cmd(MEM_READ, 6'd0, vecs[i].rd_addr);
      pop_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Command issued before its data: five stalled cycles, then the word arrives
    apply_reset();
    check("uf_wr_error_pre", bus.wr_error, 0);
    base = uf_cnt;
    push_cmd(MEM_WRITE, 6'd0, 30'h80);
    repeat (5) tick();
    push_wr(32'h1234_5678, 4'b0000);
    wait_idle("uf_write");
    check("uf_cycles", uf_cnt - base, 5);
    check("uf_wr_error", bus.wr_error, 1);
    push_cmd(MEM_READ, 6'd0, 30'h80);
    pop_check("uf_readback", 32'h1234_5678);

    apply_reset();
    for (int i = 0; i < 64; i++) push_wr(32'(i), 4'b0000);
    check("wrfull_count", bus.wr_count, 64);
    check("wrfull_full", bus.wr_full, 1);
    check("wrfull_err_pre", bus.wr_error, 0);
    push_wr(32'hffff_0000, 4'b0000);
    check("wrfull_err", bus.wr_error, 1);
    check("wrfull_count_post", bus.wr_count, 64);

    apply_reset();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rd_empty_pop_err", bus.rd_error, 1);
    check("rd_empty_pop_count", bus.rd_count, 0);

    // Stall the engine in WRITE, then fill the command FIFO past its depth
    apply_reset();
    push_cmd(MEM_WRITE, 6'd0, 30'h2c0);
    tick();
    tick();
    check("cf_cmd_empty", bus.cmd_empty, 1);
    for (int k = 1; k <= 5; k++) begin
      push_cmd((k == 5) ? MEM_WRITE : MEM_REFRESH, 6'd0, 30'h300);
      check($sformatf("cf_full_after_%0d", k), bus.cmd_full, (k >= 4) ? 1 : 0);
    end
    push_wr(32'haaaa_0001, 4'b0000);
    push_wr(32'hbbbb_0002, 4'b0000);
    wait_idle("cf_drain");
    check("cf_leftover_wr", bus.wr_count, 1);
    apply_reset();
    push_cmd(MEM_READ, 6'd0, 30'h2c0);
    pop_check("cf_readback", 32'haaaa_0001);

    // Burst wraps from the last word back to word 0
    push_wr(32'ha0a0_a0a0, 4'b0000);
    push_wr(32'hb1b1_b1b1, 4'b0000);
    push_cmd(MEM_WRITE, 6'd1, 30'hffc);
    wait_idle("wrap_write");
    push_cmd(MEM_READ, 6'd0, 30'hffc);
    pop_check("wrap_w1023", 32'ha0a0_a0a0);
    push_cmd(MEM_READ, 6'd0, 30'h000);
    pop_check("wrap_w0", 32'hb1b1_b1b1);
    push_cmd(MEM_READ, 6'd1, 30'hffc);
    exp_q.push_back(32'ha0a0_a0a0);
    exp_q.push_back(32'hb1b1_b1b1);
    drain("wrap_burst");

    // One-cycle reset in the middle of a long read
    push_cmd(MEM_READ, 6'd63, 30'h10);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midrd");
    repeat (10) tick();
    check("midrd_no_push", bus.rd_count, 0);
    push_cmd(MEM_READ, 6'd1, 30'h10);
    exp_q.push_back(32'hcafe_babe);
    exp_q.push_back(32'h1bad_1dea);
    drain("midrd_readback");

    // Two 64-word reads with no pops: the second burst is dropped entirely
    apply_reset();
    base = ov_cnt;
    push_cmd(MEM_READ, 6'd63, 30'h10);
    push_cmd(MEM_READ, 6'd63, 30'h10);
    wait_idle("ovf_issue");
    repeat (3) tick();
    check("ovf_rd_full", bus.rd_full, 1);
    check("ovf_rd_count", bus.rd_count, 64);
    check("ovf_pulses", ov_cnt - base, 64);
    check("ovf_rd_error", bus.rd_error, 1);
    check("ovf_head", bus.rd_data, 32'hcafe_babe);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("ovf_second", bus.rd_data, 32'h1bad_1dea);
    check("ovf_count_after_pop", bus.rd_count, 63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
